// File: rtl/logic_unit_arbiter_if.sv
// Request/result bus between four requesters, the shared logic-unit arbiter and the result consumer.
interface logic_unit_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic [3:0]         req;
  logic [7:0]         op_flat;
  logic [4*WIDTH-1:0] a_flat;
  logic [4*WIDTH-1:0] b_flat;
  logic [3:0]         gnt;
  logic               res_valid;
  logic [1:0]         res_id;
  logic [1:0]         res_op;
  logic [WIDTH-1:0]   res_data;
  logic               res_ready;
  logic [15:0]        ops_done;

  modport master (
    output req, op_flat, a_flat, b_flat, res_ready,
    input  gnt, res_valid, res_id, res_op, res_data, ops_done
  );

  modport slave (
    input  req, op_flat, a_flat, b_flat, res_ready,
    output gnt, res_valid, res_id, res_op, res_data, ops_done
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one OR/NOR/XOR/XNOR unit between four requesters,
// with a registered valid/ready result stage and a delivered-result counter.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  logic_unit_arbiter_if.slave bus
);

  logic [1:0]       ptr;
  logic             res_valid;
  logic [1:0]       res_id;
  logic [1:0]       res_op;
  logic [WIDTH-1:0] res_data;
  logic [15:0]      ops_done;

  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             slot_free;
  logic             grant;
  logic [3:0]       gnt_vec;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [WIDTH-1:0] alu_out;
  logic             deliver;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Gating with rst_n keeps gnt low for the whole reset, not just after the first edge.
  always_comb begin
    slot_free = !res_valid || bus.res_ready;
    grant     = rst_n && slot_free && found;
    gnt_vec   = grant ? (4'b0001 << win) : '0;
    deliver   = res_valid && bus.res_ready;
  end

  always_comb begin
    win_op = bus.op_flat[{win, 1'b0} +: 2];
    win_a  = bus.a_flat[WIDTH*win +: WIDTH];
    win_b  = bus.b_flat[WIDTH*win +: WIDTH];
    case (win_op)
      2'b00:   alu_out = win_a | win_b;
      2'b01:   alu_out = ~(win_a | win_b);
      2'b10:   alu_out = win_a ^ win_b;
      default: alu_out = ~(win_a ^ win_b);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_op    <= '0;
      res_data  <= '0;
    end else if (grant) begin
      ptr       <= win + 2'd1;
      res_valid <= 1'b1;
      res_id    <= win;
      res_op    <= win_op;
      res_data  <= alu_out;
    end else if (deliver) begin
      res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_done <= '0;
    end else if (deliver) begin
      ops_done <= ops_done + 16'd1;
    end
  end

  assign bus.gnt       = gnt_vec;
  assign bus.res_valid = res_valid;
  assign bus.res_id    = res_id;
  assign bus.res_op    = res_op;
  assign bus.res_data  = res_data;
  assign bus.ops_done  = ops_done;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: reset, op coverage, round-robin order,
// backpressure, pointer skip, mid-stream reset and ops_done wrap.
module tb_logic_unit_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic_unit_arbiter_if #(.WIDTH(4)) bus ();

  logic_unit_arbiter #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    bus.req = 4'b1111;
    #2;
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.res_valid); end
    checks++; if (bus.res_data !== 4'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.res_data); end
    checks++; if (bus.ops_done !== 16'h0) begin failures++; $display("FAIL reset_ops got=%h exp=0", bus.ops_done); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt_edge got=%b exp=0000", bus.gnt); end
    bus.req = 4'b0000;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    bus.res_ready = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      #1;
      checks++; if (bus.gnt !== exp_g) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", i, bus.gnt, exp_g); end
      @(posedge clk); #1;
      checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(i % 4)) begin
        failures++; $display("FAIL rr_id%0d got=%b/%0d exp=1/%0d", i, bus.res_valid, bus.res_id, i % 4);
      end
    end
    bus.req = 4'b0000;
    @(posedge clk); #1;
    checks++; if (bus.res_valid !== 1'b0 || bus.ops_done !== 16'd5) begin
      failures++; $display("FAIL rr_drain got=%b/%0d exp=0/5", bus.res_valid, bus.ops_done);
    end
  endtask

  task automatic test_ops();
    logic [3:0] exp_d [4];
    exp_d[0] = 4'b0111; exp_d[1] = 4'b1000; exp_d[2] = 4'b0110; exp_d[3] = 4'b1001;
    bus.res_ready = 1'b1;
    bus.a_flat = 16'h0003;
    bus.b_flat = 16'h0005;
    bus.req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      bus.op_flat = 8'(i);
      #1;
      checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL op_gnt%0d got=%b exp=0001", i, bus.gnt); end
      @(posedge clk); #1;
      checks++; if (bus.res_data !== exp_d[i] || bus.res_id !== 2'd0 || bus.res_op !== 2'(i)) begin
        failures++; $display("FAIL op_res%0d got=%b id=%0d op=%0d exp=%b id=0 op=%0d", i, bus.res_data, bus.res_id, bus.res_op, exp_d[i], i);
      end
    end
    bus.req = 4'b0000;
    @(posedge clk); #1;
    checks++; if (bus.ops_done !== 16'd9 || bus.res_valid !== 1'b0) begin
      failures++; $display("FAIL op_count got=%0d/%b exp=9/0", bus.ops_done, bus.res_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    bus.op_flat = 8'b0000_0010;
    bus.a_flat = 16'h0C03;
    bus.b_flat = 16'h0A05;
    bus.req = 4'b0001;
    #1;
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL bp_first_gnt got=%b exp=0001", bus.gnt); end
    @(posedge clk); #1;
    bus.req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.gnt !== 4'b0000 || bus.res_data !== 4'b0110 || bus.res_valid !== 1'b1) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%b/%b exp=0000/0110/1", i, bus.gnt, bus.res_data, bus.res_valid);
      end
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL bp_release_gnt got=%b exp=0100", bus.gnt); end
    @(posedge clk); #1;
    bus.req = 4'b0000;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2 || bus.res_data !== 4'b1110 || bus.ops_done !== 16'd10) begin
      failures++; $display("FAIL bp_b2b got=%b/%0d/%b/%0d exp=1/2/1110/10", bus.res_valid, bus.res_id, bus.res_data, bus.ops_done);
    end
    @(posedge clk); #1;
    checks++; if (bus.res_valid !== 1'b0 || bus.ops_done !== 16'd11) begin
      failures++; $display("FAIL bp_drain got=%b/%0d exp=0/11", bus.res_valid, bus.ops_done);
    end
  endtask

  task automatic test_pointer_skip();
    bus.res_ready = 1'b1;
    bus.req = 4'b0110;
    #1;
    checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL skip_gnt1 got=%b exp=0010", bus.gnt); end
    @(posedge clk); #1;
    bus.req = 4'b0100;
    #1;
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL skip_gnt2 got=%b exp=0100", bus.gnt); end
    @(posedge clk); #1;
    bus.req = 4'b0000;
    checks++; if (bus.res_id !== 2'd2 || bus.ops_done !== 16'd12) begin
      failures++; $display("FAIL skip_id got=%0d/%0d exp=2/12", bus.res_id, bus.ops_done);
    end
    @(posedge clk); #1;
    checks++; if (bus.ops_done !== 16'd13) begin failures++; $display("FAIL skip_count got=%0d exp=13", bus.ops_done); end
  endtask

  task automatic test_mid_reset();
    bus.res_ready = 1'b0;
    bus.req = 4'b0001;
    @(posedge clk); #1;
    checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL mr_pending got=%b exp=1", bus.res_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0 || bus.res_id !== 2'd0 || bus.res_op !== 2'd0 || bus.res_data !== 4'h0 || bus.ops_done !== 16'h0 || bus.gnt !== 4'b0000) begin
      failures++; $display("FAIL mr_async got=v%b id%0d op%0d d%h n%0d g%b exp=all zero", bus.res_valid, bus.res_id, bus.res_op, bus.res_data, bus.ops_done, bus.gnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    bus.req = 4'b1010;
    #1;
    checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL mr_ptr0 got=%b exp=0010", bus.gnt); end
    @(posedge clk); #1;
    bus.req = 4'b0000;
    checks++; if (bus.res_id !== 2'd1) begin failures++; $display("FAIL mr_id got=%0d exp=1", bus.res_id); end
    @(posedge clk); #1;
    checks++; if (bus.ops_done !== 16'd1) begin failures++; $display("FAIL mr_count got=%0d exp=1", bus.ops_done); end
  endtask

  task automatic test_counter_wrap();
    bus.res_ready = 1'b1;
    bus.req = 4'b0001;
    repeat (65535) @(posedge clk);
    #1;
    checks++; if (bus.ops_done !== 16'hFFFF) begin failures++; $display("FAIL wrap_max got=%h exp=ffff", bus.ops_done); end
    bus.req = 4'b0000;
    @(posedge clk); #1;
    checks++; if (bus.ops_done !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", bus.ops_done); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.req = '0;
    bus.op_flat = '0;
    bus.a_flat = '0;
    bus.b_flat = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_ops();
    test_backpressure();
    test_pointer_skip();
    test_mid_reset();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
